demux_router: RTL

- Parametrised, registered 1-to-N demultiplexer with valid/ready handshake on the input and on every output channel.
- Each accepted input word is steered by `select` into a one-entry holding register for the chosen channel.
- A registered one-hot decode of the last accepted select is also provided.
- Sits between a single producer and N independent consumers in lab datapaths; replaces the fixed 1-bit, 4-way combinational decoder.

---
 rtl/demux_router_if.sv | 29 ++
 rtl/demux_router.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/demux_router_if.sv
// Handshake bundle for demux_router: one producer side and N consumer channels.
// The router uses the slave modport. The producer/consumer side uses master.
interface demux_router_if #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 8
);
  logic [DATA_W-1:0]      in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic [SEL_W-1:0]       select;
  logic [N_CH*DATA_W-1:0] out_data;
  logic [N_CH-1:0]        out_valid;
  logic [N_CH-1:0]        out_ready;
  logic [N_CH-1:0]        dec_onehot;
  logic                   sel_err;
  logic [N_CH*CNT_W-1:0]  cnt_bus;

  modport slave (
    input  in_data, in_valid, select, out_ready,
    output in_ready, out_data, out_valid, dec_onehot, sel_err, cnt_bus
  );

  modport master (
    output in_data, in_valid, select, out_ready,
    input  in_ready, out_data, out_valid, dec_onehot, sel_err, cnt_bus
  );
endinterface

// File: rtl/demux_router.sv
// demux_router: registered 1-to-N demultiplexer with valid/ready on every side.
// Each channel owns a one-entry holding register, controlled by an EMPTY/FULL FSM.
// When the macro DEMUX_ROUTER_COUNT_EN is defined, each channel gets a saturating
// counter of accepted words. When it is not defined, cnt_bus is tied to zero.
module demux_router #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 8
) (
  input  logic          clk,
  input  logic          rst,
  demux_router_if.slave bus
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} ch_state_t;

  logic [N_CH-1:0]        sel_hit;
  logic [N_CH-1:0]        ch_open;
  logic [N_CH-1:0]        load;
  logic [N_CH-1:0]        valid_vec;
  logic [N_CH*DATA_W-1:0] data_flat;
  logic                   in_range;
  logic                   in_ready_int;
  logic                   acc;

  logic [N_CH-1:0]        dec_reg, dec_next;
  logic                   sel_err_reg, sel_err_next;

  // Each channel decodes the select by itself. Out-of-range selects produce no hit.
  // This avoids indexing past N_CH.
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_decode
    assign sel_hit[gi] = (bus.select == SEL_W'(gi));
    assign ch_open[gi] = ~valid_vec[gi] | bus.out_ready[gi];
  end

  assign in_range     = |sel_hit;
  // An out-of-range word is always accepted, and it is then discarded.
  assign in_ready_int = in_range ? |(sel_hit & ch_open) : 1'b1;
  assign acc          = bus.in_valid & in_ready_int;
  assign load         = {N_CH{acc}} & sel_hit;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    ch_state_t         state_reg, state_next;
    logic [DATA_W-1:0] data_reg, data_next;

    // Register the channel state and its held word.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_reg <= EMPTY;
        data_reg  <= '0;
      end else begin
        state_reg <= state_next;
        data_reg  <= data_next;
      end
    end

    // A load always wins. A drain without a load empties the channel.
    // The held data is kept in every other case.
    always_comb begin
      state_next = state_reg;
      data_next  = data_reg;
      case (state_reg)
        EMPTY: begin
          if (load[gi]) begin
            state_next = FULL;
            data_next  = bus.in_data;
          end
        end
        FULL: begin
          if (load[gi]) begin
            data_next  = bus.in_data;
          end else if (bus.out_ready[gi]) begin
            state_next = EMPTY;
          end
        end
        default: state_next = EMPTY;
      endcase
    end

    assign valid_vec[gi]                     = (state_reg == FULL);
    assign data_flat[gi*DATA_W +: DATA_W]    = data_reg;
  end

  // Register the one-hot of the last in-range accept and the drop pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      dec_reg     <= '0;
      sel_err_reg <= 1'b0;
    end else begin
      dec_reg     <= dec_next;
      sel_err_reg <= sel_err_next;
    end
  end

  // dec_onehot only moves on an in-range accept. sel_err marks a dropped word.
  always_comb begin
    dec_next     = dec_reg;
    sel_err_next = acc & ~in_range;
    if (acc && in_range) begin
      dec_next = sel_hit;
    end
  end

`ifdef DEMUX_ROUTER_COUNT_EN
  logic [N_CH*CNT_W-1:0] cnt_flat;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_cnt
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    // Register the per-channel accepted-word count.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_reg <= '0;
      end else begin
        cnt_reg <= cnt_next;
      end
    end

    // Count the in-range loads. The counter sticks at all-ones.
    always_comb begin
      cnt_next = cnt_reg;
      if (load[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
        cnt_next = cnt_reg + CNT_W'(1);
      end
    end

    assign cnt_flat[gi*CNT_W +: CNT_W] = cnt_reg;
  end

  assign bus.cnt_bus = cnt_flat;
`else
  assign bus.cnt_bus = {(N_CH*CNT_W){1'b0}};
`endif

  assign bus.in_ready   = in_ready_int;
  assign bus.out_valid  = valid_vec;
  assign bus.out_data   = data_flat;
  assign bus.dec_onehot = dec_reg;
  assign bus.sel_err    = sel_err_reg;

endmodule
